// File: rtl/convo_2d_mc_if.sv
// Handshake and BRAM port bundle for the convo_2d_mc engine.
// The master side is the layer controller plus the three BRAMs; the slave side is the engine.
interface convo_2d_mc_if #(
   parameter int DataWidth     = 8,
   parameter int ActvAddrWidth = 11,
   parameter int WgtAddrWidth  = 7,
   parameter int OutAddrWidth  = 12
);
   logic                     req_i;
   logic                     ack_o;
   logic                     req_o;
   logic                     ack_i;
   logic                     ready_o;
   logic [ActvAddrWidth-1:0] actv_ram_addr;
   logic [DataWidth-1:0]     actv_ram_din;
   logic [WgtAddrWidth-1:0]  wgt_ram_addr;
   logic [DataWidth-1:0]     wgt_ram_din;
   logic [OutAddrWidth-1:0]  out_ram_addr;
   logic                     out_ram_we;
   logic [DataWidth-1:0]     out_ram_dout;
   logic                     ovf_o;

   modport master (
      output req_i, ack_i, actv_ram_din, wgt_ram_din,
      input  ack_o, req_o, ready_o, actv_ram_addr, wgt_ram_addr,
             out_ram_addr, out_ram_we, out_ram_dout, ovf_o
   );

   modport slave (
      input  req_i, ack_i, actv_ram_din, wgt_ram_din,
      output ack_o, req_o, ready_o, actv_ram_addr, wgt_ram_addr,
             out_ram_addr, out_ram_we, out_ram_dout, ovf_o
   );
endinterface

// File: rtl/convo_2d_mc.sv
// Multi-channel 2D convolution engine with a private single-cycle MAC, stride, zero padding,
// saturating fixed-point rounding and optional ReLU; one tap per cycle, K+2 cycles per pixel.
module convo_2d_mc #(
   parameter int DataWidth     = 8,
   parameter int FpWidth       = 4,
   parameter int KernelW       = 3,
   parameter int KernelH       = 3,
   parameter int DataSizeW     = 28,
   parameter int DataSizeH     = 28,
   parameter int NumInCh       = 2,
   parameter int NumOutCh      = 4,
   parameter int Stride        = 1,
   parameter int Pad           = 0,
   parameter int Relu          = 1,
   parameter int OutW          = (DataSizeW + 2*Pad - KernelW) / Stride + 1,
   parameter int OutH          = (DataSizeH + 2*Pad - KernelH) / Stride + 1,
   parameter int ActvAddrWidth = $clog2(NumInCh*DataSizeW*DataSizeH),
   parameter int WgtAddrWidth  = $clog2(NumOutCh*NumInCh*KernelW*KernelH),
   parameter int OutAddrWidth  = $clog2(NumOutCh*OutW*OutH),
   parameter int AccWidth      = 2*DataWidth + $clog2(NumInCh*KernelW*KernelH) + 1
) (
   input logic           clk_i,
   input logic           reset_i,
   convo_2d_mc_if.slave  bus
);
   localparam int KxW = $clog2(KernelW + 1);
   localparam int KyW = $clog2(KernelH + 1);
   localparam int IcW = $clog2(NumInCh + 1);
   localparam int OxW = $clog2(OutW + 1);
   localparam int OyW = $clog2(OutH + 1);
   localparam int OcW = $clog2(NumOutCh + 1);
   localparam int PrW = 2*DataWidth;

   localparam logic [KxW-1:0] KxLast = KxW'(KernelW - 1);
   localparam logic [KyW-1:0] KyLast = KyW'(KernelH - 1);
   localparam logic [IcW-1:0] IcLast = IcW'(NumInCh - 1);
   localparam logic [OxW-1:0] OxLast = OxW'(OutW - 1);
   localparam logic [OyW-1:0] OyLast = OyW'(OutH - 1);
   localparam logic [OcW-1:0] OcLast = OcW'(NumOutCh - 1);

   localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((2**(DataWidth-1)) - 1);
   localparam logic signed [AccWidth-1:0] SatMin = AccWidth'(-(2**(DataWidth-1)));

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACK     = 3'd1,
      S_MAC     = 3'd2,
      S_DRAIN   = 3'd3,
      S_WRITE   = 3'd4,
      S_DONE    = 3'd5,
      S_WAITLOW = 3'd6
   } state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic [KxW-1:0]              r_kx;
   logic [KyW-1:0]              r_ky;
   logic [IcW-1:0]              r_ic;
   logic [OxW-1:0]              r_ox;
   logic [OyW-1:0]              r_oy;
   logic [OcW-1:0]              r_oc;
   logic                        r_tap_vld;
   logic                        r_tap_pad;
   logic                        r_tap_first;
   logic signed [AccWidth-1:0]  r_acc;
   logic                        r_ovf;

   int                          w_ix;
   int                          w_iy;
   logic                        w_pad;
   logic                        w_last_tap;
   logic                        w_last_pix;
   logic signed [DataWidth-1:0] w_actv_op;
   logic signed [PrW-1:0]       w_prod;
   logic signed [AccWidth-1:0]  w_prod_ext;
   logic signed [AccWidth-1:0]  w_shift;
   logic signed [DataWidth-1:0] w_sat;
   logic signed [DataWidth-1:0] w_result;
   logic                        w_clip;

   // Input coordinate of the current tap and loop-end detection
   always_comb begin
      w_ix       = int'(r_ox) * Stride + int'(r_kx) - Pad;
      w_iy       = int'(r_oy) * Stride + int'(r_ky) - Pad;
      w_pad      = (w_ix < 0) || (w_ix >= DataSizeW) || (w_iy < 0) || (w_iy >= DataSizeH);
      w_last_tap = (r_kx == KxLast) && (r_ky == KyLast) && (r_ic == IcLast);
      w_last_pix = (r_ox == OxLast) && (r_oy == OyLast) && (r_oc == OcLast);
   end

   // MAC product and the saturate/ReLU result path
   always_comb begin
      w_actv_op  = r_tap_pad ? '0 : $signed(bus.actv_ram_din);
      w_prod     = PrW'(w_actv_op) * PrW'($signed(bus.wgt_ram_din));
      w_prod_ext = AccWidth'(w_prod);
      w_shift    = r_acc >>> FpWidth;
      if (w_shift > SatMax) begin
         w_sat  = SatMax[DataWidth-1:0];
         w_clip = 1'b1;
      end else if (w_shift < SatMin) begin
         w_sat  = SatMin[DataWidth-1:0];
         w_clip = 1'b1;
      end else begin
         w_sat  = w_shift[DataWidth-1:0];
         w_clip = 1'b0;
      end
      w_result = ((Relu != 0) && w_sat[DataWidth-1]) ? '0 : w_sat;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = bus.req_i ? S_ACK : S_IDLE;
         S_ACK:     w_next = S_MAC;
         S_MAC:     w_next = w_last_tap ? S_DRAIN : S_MAC;
         S_DRAIN:   w_next = S_WRITE;
         S_WRITE:   w_next = w_last_pix ? S_DONE : S_MAC;
         S_DONE:    w_next = bus.ack_i ? S_WAITLOW : S_DONE;
         S_WAITLOW: w_next = bus.req_i ? S_WAITLOW : S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // BRAM address/strobe outputs; a padding tap reads address 0 and is masked a cycle later
   always_comb begin
      bus.actv_ram_addr = '0;
      bus.wgt_ram_addr  = '0;
      bus.out_ram_addr  = '0;
      bus.out_ram_we    = 1'b0;
      bus.out_ram_dout  = '0;
      if (r_state == S_MAC) begin
         if (w_pad) begin
            bus.actv_ram_addr = '0;
         end else begin
            bus.actv_ram_addr = ActvAddrWidth'(int'(r_ic)*DataSizeW*DataSizeH + w_iy*DataSizeW + w_ix);
         end
         bus.wgt_ram_addr = WgtAddrWidth'(((int'(r_oc)*NumInCh + int'(r_ic))*KernelH
                                          + int'(r_ky))*KernelW + int'(r_kx));
      end else if (r_state == S_WRITE) begin
         bus.out_ram_addr = OutAddrWidth'(int'(r_oc)*OutH*OutW + int'(r_oy)*OutW + int'(r_ox));
         bus.out_ram_we   = 1'b1;
         bus.out_ram_dout = w_result;
      end else begin
         bus.out_ram_we = 1'b0;
      end
   end

   assign bus.ready_o = (r_state == S_IDLE);
   assign bus.ack_o   = (r_state == S_ACK);
   assign bus.req_o   = (r_state == S_DONE) && !bus.ack_i;
   assign bus.ovf_o   = r_ovf;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Tap loop (kx, ky, ic) advances per MAC cycle; pixel loop (ox, oy, oc) per WRITE
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_kx <= '0; r_ky <= '0; r_ic <= '0;
         r_ox <= '0; r_oy <= '0; r_oc <= '0;
      end else begin
         case (r_state)
            S_ACK: begin
               r_kx <= '0; r_ky <= '0; r_ic <= '0;
               r_ox <= '0; r_oy <= '0; r_oc <= '0;
            end
            S_MAC: begin
               r_kx <= (r_kx == KxLast) ? '0 : r_kx + 1'b1;
               if (r_kx == KxLast) begin
                  r_ky <= (r_ky == KyLast) ? '0 : r_ky + 1'b1;
                  if (r_ky == KyLast) begin
                     r_ic <= (r_ic == IcLast) ? '0 : r_ic + 1'b1;
                  end
               end
            end
            S_WRITE: begin
               r_ox <= (r_ox == OxLast) ? '0 : r_ox + 1'b1;
               if (r_ox == OxLast) begin
                  r_oy <= (r_oy == OyLast) ? '0 : r_oy + 1'b1;
                  if (r_oy == OyLast) begin
                     r_oc <= (r_oc == OcLast) ? '0 : r_oc + 1'b1;
                  end
               end
            end
            default: begin
               r_kx <= r_kx;
            end
         endcase
      end
   end

   // Tap pipeline, accumulator and sticky overflow flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_tap_vld   <= 1'b0;
         r_tap_pad   <= 1'b0;
         r_tap_first <= 1'b0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_tap_vld   <= (r_state == S_MAC);
         r_tap_pad   <= (r_state == S_MAC) && w_pad;
         r_tap_first <= (r_state == S_MAC) && (r_kx == '0) && (r_ky == '0) && (r_ic == '0);
         if (r_state == S_ACK) begin
            r_acc <= '0;
         end else if (r_tap_vld) begin
            r_acc <= r_tap_first ? w_prod_ext : r_acc + w_prod_ext;
         end else begin
            r_acc <= r_acc;
         end
         if (r_state == S_ACK) begin
            r_ovf <= 1'b0;
         end else if ((r_state == S_WRITE) && w_clip) begin
            r_ovf <= 1'b1;
         end else begin
            r_ovf <= r_ovf;
         end
      end
   end
endmodule
